inv_mont_gen: RTL and testbench

- Parametrised modular inverter for odd moduli, successor of the fixed-width Montgomery inverse block.
- Phase 1: Kaliski almost-inverse, r = X^-1·2^k mod M.
- Phase 2: shifts the exponent to a selectable target, so one block serves plain inversion, Montgomery-inverse and Montgomery-domain-to-Montgomery-domain inversion.
- Detects non-invertible operands and reports them instead of returning garbage. Sits beside the field multiplier in the X448/X25519 scalar-multiplication datapath.

---
 rtl/inv_mont_gen.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_inv_mont_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mont_gen.sv
// -----------------------------------------------------------------------------
// inv_mont_gen -- parametrised modular inverter for odd moduli.
//
// Phase 1 runs the Kaliski almost-inverse and produces r = X^-1 * 2^k mod M,
// where k is the iteration count. Phase 2 walks the exponent to a target T
// chosen by mode, so the block returns X^-1 * 2^T mod M. Operands that are
// not invertible, and illegal moduli, are flagged with res_err and R = 0.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset; aborts any operation
//   req_valid  request valid
//   req_ready  block can accept a request (high only while idle)
//   X          operand, captured on the request handshake
//   M          modulus, captured on the request handshake (odd, >= 3)
//   mode       0: T=0, 1: T=N, 2: T=2N, 3: same as 0
//   busy       high from accept until res_valid rises
//   res_valid  result valid, held until res_ready
//   res_ready  consumer accepts the result
//   R          result in [1, M-1], or 0 when res_err
//   res_err    operand not invertible or modulus illegal
// -----------------------------------------------------------------------------
module inv_mont_gen #(
  parameter int N  = 448,
  parameter int KW = $clog2(2 * N + 1) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] M,
  input  logic [1:0]   mode,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] R,
  output logic         res_err
);

  // r and s need one extra bit: both stay below 2M.
  localparam int NW = N + 1;

  localparam logic [KW-1:0] T_N  = KW'(N);
  localparam logic [KW-1:0] T_2N = KW'(2 * N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PH1,
    S_FIX,
    S_PH2,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  m_q, m_d;
  logic [1:0]    mode_q, mode_d;
  logic [N-1:0]  u_q, u_d;
  logic [N-1:0]  v_q, v_d;
  logic [NW-1:0] r_q, r_d;
  logic [NW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  res_q, res_d;
  logic          err_q, err_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [NW-1:0] m_ext;
  logic          operand_bad;
  logic [KW-1:0] tgt;

  assign m_ext = {1'b0, m_q};

  // Anything that cannot have an inverse, or that would break the Kaliski
  // loop (even or tiny modulus, zero operand), is rejected before Phase 1.
  assign operand_bad = (x_q == '0) || (x_q >= m_q) || !m_q[0] || (m_q < N'(3));

  always_comb begin
    case (mode_q)
      2'd1:    tgt = T_N;
      2'd2:    tgt = T_2N;
      default: tgt = '0;
    endcase
  end

  // One Kaliski iteration. The branch order matters: even u first, then
  // even v, then the subtract-and-halve cases.
  logic [N-1:0]  u_nx, v_nx;
  logic [NW-1:0] r_nx, s_nx;
  logic [N-1:0]  u_sub_v, v_sub_u;
  logic [NW-1:0] r_add_s;

  assign u_sub_v = u_q - v_q;
  assign v_sub_u = v_q - u_q;
  assign r_add_s = r_q + s_q;

  // NOTE: every variable driven from always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    u_nx = u_q;
    v_nx = v_q;
    r_nx = r_q;
    s_nx = s_q;
    if (!u_q[0]) begin
      u_nx = u_q >> 1;
      s_nx = s_q << 1;
    end else if (!v_q[0]) begin
      v_nx = v_q >> 1;
      r_nx = r_q << 1;
    end else if (u_q > v_q) begin
      u_nx = u_sub_v >> 1;
      r_nx = r_add_s;
      s_nx = s_q << 1;
    end else begin
      v_nx = v_sub_u >> 1;
      s_nx = r_add_s;
      r_nx = r_q << 1;
    end
  end

  // Phase-1 result lies in [0, 2M); reduce once, then negate mod M.
  logic [NW-1:0] r_mod, r_fix;

  assign r_mod = (r_q >= m_ext) ? (r_q - m_ext) : r_q;
  assign r_fix = m_ext - r_mod;

  // Phase-2 steps. Halving mod M: odd r is made even by adding M (M is odd),
  // then shifted; r + M < 2M fits in NW bits. Doubling: 2r < 2M, one
  // conditional subtract brings it back below M.
  logic [NW-1:0] r_odd_sum, r_half, r_dbl, r_dbl_mod;

  assign r_odd_sum = r_q[0] ? (r_q + m_ext) : r_q;
  assign r_half    = r_odd_sum >> 1;
  assign r_dbl     = r_q << 1;
  assign r_dbl_mod = (r_dbl >= m_ext) ? (r_dbl - m_ext) : r_dbl;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    m_d     = m_q;
    mode_d  = mode_q;
    u_d     = u_q;
    v_d     = v_q;
    r_d     = r_q;
    s_d     = s_q;
    k_d     = k_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          x_d     = X;
          m_d     = M;
          mode_d  = mode;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (operand_bad) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          u_d     = m_q;
          v_d     = x_q;
          r_d     = '0;
          s_d     = NW'(1);
          k_d     = '0;
          state_d = S_PH1;
        end
      end

      S_PH1: begin
        u_d = u_nx;
        v_d = v_nx;
        r_d = r_nx;
        s_d = s_nx;
        k_d = k_q + KW'(1);
        // When v reaches zero, u holds gcd(X, M).
        if (v_nx == '0) begin
          if (u_nx != N'(1)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        r_d     = r_fix;
        state_d = S_PH2;
      end

      S_PH2: begin
        if (k_q > tgt) begin
          r_d = r_half;
          k_d = k_q - KW'(1);
        end else if (k_q < tgt) begin
          r_d = r_dbl_mod;
          k_d = k_q + KW'(1);
        end else begin
          res_d   = r_q[N-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
          x_d     = '0;
          m_d     = '0;
          mode_d  = '0;
          u_d     = '0;
          v_d     = '0;
          r_d     = '0;
          s_d     = '0;
          k_d     = '0;
          res_d   = '0;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order. Reset clears every
  // register (there is no memory array here), so an aborted operation leaves
  // nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      m_q     <= '0;
      mode_q  <= '0;
      u_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      mode_q  <= mode_d;
      u_q     <= u_d;
      v_q     <= v_d;
      r_q     <= r_d;
      s_q     <= s_d;
      k_q     <= k_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_CHECK) || (state_q == S_PH1) ||
                     (state_q == S_FIX)   || (state_q == S_PH2);
  assign res_valid = (state_q == S_DONE);
  assign R         = res_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_inv_mont_gen.sv
// -----------------------------------------------------------------------------
// tb_inv_mont_gen -- self-checking bench for inv_mont_gen.
//
// Two instances: N=8 for exact, brute-force-modelled results and protocol
// corners, and N=448 on the Goldilocks prime where each result is checked by
// the defining congruence X*R == 2^T (mod M).
// -----------------------------------------------------------------------------
module tb_inv_mont_gen;

  localparam int SN = 8;
  localparam int WN = 448;

  localparam logic [511:0] MW = (512'(1) << 448) - (512'(1) << 224) - 512'(1);

  typedef struct {
    logic [511:0] x;
    logic [511:0] m;
    logic [511:0] r;
    int           t;
    bit           err;
    int           lat;   // exact expected latency, or -1 for bound only
  } exp_t;

  // ---------------------------------------------------------------------------
  // Clock, reset, cycle counter
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic          rv8 = 1'b0, rdy8 = 1'b1;
  logic          rr8, busy8, vv8, e8;
  logic [SN-1:0] x8 = '0, m8 = '0, r8;
  logic [1:0]    md8 = '0;

  logic          rvw = 1'b0, rdyw = 1'b1;
  logic          rrw, busyw, vvw, ew;
  logic [WN-1:0] xw = '0, mw = '0, rw;
  logic [1:0]    mdw = '0;

  inv_mont_gen #(.N(SN)) dut8 (
    .clk(clk), .rst(rst),
    .req_valid(rv8), .req_ready(rr8), .X(x8), .M(m8), .mode(md8),
    .busy(busy8), .res_valid(vv8), .res_ready(rdy8), .R(r8), .res_err(e8)
  );

  inv_mont_gen #(.N(WN)) dutw (
    .clk(clk), .rst(rst),
    .req_valid(rvw), .req_ready(rrw), .X(xw), .M(mw), .mode(mdw),
    .busy(busyw), .res_valid(vvw), .res_ready(rdyw), .R(rw), .res_err(ew)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference for small widths: search R in [1, M-1] with X*R == 2^T mod M.
  // No such R exists exactly when X is not invertible.
  function automatic void model_small(input int x, input int m, input int md,
                                      output int r, output bit err);
    int t, tgt;
    t   = (md == 1) ? SN : (md == 2) ? 2 * SN : 0;
    r   = 0;
    err = 1'b1;
    if (x == 0 || x >= m || (m % 2) == 0 || m < 3) return;
    tgt = (1 << t) % m;
    for (int c = 1; c < m; c++) begin
      if ((x * c) % m == tgt) begin
        r   = c;
        err = 1'b0;
        return;
      end
    end
  endfunction

  function automatic logic [511:0] pow2mod(input int t, input logic [511:0] m);
    logic [1023:0] p;
    p = 1024'(1) << t;
    p = p % {512'b0, m};
    return p[511:0];
  endfunction

  function automatic logic [511:0] rnd448();
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 14; j++) v[j*32 +: 32] = $urandom;
    v = v % MW;
    if (v == '0) v = 512'(1);
    return v;
  endfunction

  exp_t q8[$];
  exp_t qw[$];

  // ---------------------------------------------------------------------------
  // Compare process: sampled on the falling edge
  // ---------------------------------------------------------------------------
  bit            held8 = 0, heldw = 0;
  logic [SN-1:0] hr8;
  logic [WN-1:0] hrw;
  logic          he8, hew;
  int            acc8 = 0, accw = 0, done8 = 0, donew = 0;
  exp_t          e8x, ewx;
  logic [1023:0] prod;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      held8 = 0;
      heldw = 0;
    end else begin
      if (rv8 && rr8) acc8 = cyc;
      if (rvw && rrw) accw = cyc;

      if (vv8) begin
        if (!held8) begin
          if (q8.size() == 0) begin
            check("s_unexpected_result", vv8, 1'b0);
          end else begin
            e8x = q8.pop_front();
            check("s_R", r8, e8x.r);
            check("s_err", e8, e8x.err);
            if (e8x.lat >= 0) check("s_latency", cyc - acc8, e8x.lat);
            check("s_latency_bound", (cyc - acc8) <= 4 * SN + 4, 1'b1);
          end
          held8 = 1;
          hr8   = r8;
          he8   = e8;
        end else begin
          check("s_R_stable", r8, hr8);
          check("s_err_stable", e8, he8);
        end
        check("s_req_ready_low", rr8, 1'b0);
        check("s_busy_low", busy8, 1'b0);
        if (rdy8) begin
          held8 = 0;
          done8++;
        end
      end

      if (vvw) begin
        if (!heldw) begin
          if (qw.size() == 0) begin
            check("w_unexpected_result", vvw, 1'b0);
          end else begin
            ewx  = qw.pop_front();
            prod = ({512'b0, ewx.x} * {512'b0, 64'b0, rw}) % {512'b0, ewx.m};
            check("w_XR_eq_2T", prod[511:0], pow2mod(ewx.t, ewx.m));
            check("w_R_range", (rw != '0) && ({64'b0, rw} < ewx.m), 1'b1);
            check("w_err", ew, 1'b0);
            check("w_latency_bound", (cyc - accw) <= 4 * WN + 4, 1'b1);
          end
          heldw = 1;
          hrw   = rw;
          hew   = ew;
        end else begin
          check("w_R_stable", rw, hrw);
          check("w_err_stable", ew, hew);
        end
        check("w_req_ready_low", rrw, 1'b0);
        if (rdyw) begin
          heldw = 0;
          donew++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  int n_sent8 = 0;
  int n_sentw = 0;

  task automatic send8(input int x, input int m, input int md, input int lat, input bit expect_res);
    exp_t e;
    int   r, w;
    bit   er;
    model_small(x, m, md, r, er);
    e.x = 512'(x); e.m = 512'(m); e.r = 512'(r); e.err = er; e.t = 0; e.lat = lat;
    w = 0;
    while (!rr8 && w < 100) begin @(posedge clk); #1; w++; end
    check("s_ready_wait", rr8, 1'b1);
    if (expect_res) begin
      q8.push_back(e);
      n_sent8++;
    end
    rv8 = 1'b1; x8 = SN'(x); m8 = SN'(m); md8 = 2'(md);
    @(posedge clk); #1;
    rv8 = 1'b0;
  endtask

  task automatic wait_done8();
    int w;
    w = 0;
    while (done8 < n_sent8 && w < 300) begin @(posedge clk); #1; w++; end
    check("s_done_wait", done8 >= n_sent8, 1'b1);
  endtask

  task automatic op8(input int x, input int m, input int md, input int lat);
    send8(x, m, md, lat, 1'b1);
    wait_done8();
  endtask

  task automatic opw(input logic [511:0] x, input int md);
    exp_t e;
    int   w;
    e.x = x; e.m = MW; e.r = '0; e.err = 1'b0; e.lat = -1;
    e.t = (md == 1) ? WN : (md == 2) ? 2 * WN : 0;
    w = 0;
    while (!rrw && w < 100) begin @(posedge clk); #1; w++; end
    check("w_ready_wait", rrw, 1'b1);
    qw.push_back(e);
    n_sentw++;
    rvw = 1'b1; xw = x[WN-1:0]; mw = MW[WN-1:0]; mdw = 2'(md);
    @(posedge clk); #1;
    rvw = 1'b0;
    w = 0;
    while (donew < n_sentw && w < 2500) begin @(posedge clk); #1; w++; end
    check("w_done_wait", donew >= n_sentw, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int           r, w;
    bit           er;
    logic [511:0] xr;

    // Reset state, observed while reset is still asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_req_ready", rr8, 1'b1);
    check("rst_s_busy", busy8, 1'b0);
    check("rst_s_res_valid", vv8, 1'b0);
    check("rst_s_R", r8, '0);
    check("rst_s_err", e8, 1'b0);
    check("rst_w_req_ready", rrw, 1'b1);
    check("rst_w_busy", busyw, 1'b0);
    check("rst_w_res_valid", vvw, 1'b0);
    rst = 1'b0;

    // Pin the reference models to hand-computed values.
    model_small(3, 13, 0, r, er);  check("pin_13_3_m0", r, 9);
    model_small(3, 13, 1, r, er);  check("pin_13_3_m1", r, 3);
    model_small(3, 13, 2, r, er);  check("pin_13_3_m2", r, 1);
    model_small(12, 13, 0, r, er); check("pin_13_12_m0", r, 12);
    model_small(5, 15, 0, r, er);  check("pin_15_5_err", er, 1'b1);
    model_small(3, 14, 0, r, er);  check("pin_14_3_err", er, 1'b1);
    check("pin_pow2_448", pow2mod(448, MW), (512'(1) << 224) + 512'(1));

    // Directed small-width operations.
    op8(3, 13, 0, -1);
    op8(3, 13, 1, -1);
    op8(3, 13, 2, -1);
    op8(3, 13, 3, -1);
    op8(1, 13, 0, -1);
    op8(12, 13, 0, -1);
    op8(0, 13, 0, 2);
    op8(5, 15, 0, -1);
    op8(3, 14, 0, 2);
    op8(13, 13, 1, 2);
    op8(1, 1, 0, 2);
    op8(250, 251, 2, -1);
    op8(7, 255, 1, -1);
    op8(5, 255, 0, -1);

    // A request presented while busy must be ignored.
    send8(3, 13, 0, -1, 1'b1);
    rv8 = 1'b1; x8 = 8'd5; m8 = 8'd13; md8 = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    rv8 = 1'b0;
    wait_done8();

    // Consumer stalls for 20 cycles, then a back-to-back request follows.
    rdy8 = 1'b0;
    send8(3, 13, 0, -1, 1'b1);
    w = 0;
    while (!vv8 && w < 100) begin @(posedge clk); #1; w++; end
    check("s_hold_reached", vv8, 1'b1);
    repeat (20) begin
      @(posedge clk); #1;
      check("s_hold_valid", vv8, 1'b1);
    end
    rdy8 = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_release", rr8, 1'b1);
    check("s_valid_after_release", vv8, 1'b0);
    send8(3, 13, 0, -1, 1'b1);
    wait_done8();

    // Reset while Phase 1 is running discards the operation.
    send8(3, 13, 2, -1, 1'b0);
    @(posedge clk); #1;
    check("s_busy_before_abort", busy8, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_req_ready", rr8, 1'b1);
    check("abort_busy", busy8, 1'b0);
    check("abort_res_valid", vv8, 1'b0);
    check("abort_R", r8, '0);
    check("abort_err", e8, 1'b0);
    rst = 1'b0;
    op8(3, 13, 0, -1);

    // Full width on M = 2^448 - 2^224 - 1.
    opw(512'(1), 0);
    opw(512'(1), 1);
    opw(512'(1), 2);
    opw(MW - 512'(1), 1);
    for (int i = 0; i < 3; i++) begin
      xr = rnd448();
      for (int md = 0; md < 3; md++) opw(xr, md);
    end

    check("s_queue_drained", q8.size(), 0);
    check("w_queue_drained", qw.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
